alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 109 ++++++++++
 tb/tb_alu_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU+shifter between two requesters.
// One operation in flight: accept, wait ALU_LAT+1 cycles, hold the response until consumed.
module alu_arbiter #(
    parameter int ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [13:0] req0_op,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [13:0] req1_op,
    output logic        req1_ready,
    output logic [3:0]  alu_A,
    output logic [3:0]  alu_B,
    output logic [2:0]  alu_S,
    output logic [1:0]  alu_H,
    output logic        alu_Cin,
    input  logic [3:0]  alu_F,
    input  logic        alu_Cout,
    input  logic [3:0]  alu_O,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [3:0]  rsp_F,
    output logic        rsp_Cout,
    output logic [3:0]  rsp_O,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state;
    logic [13:0] op_reg;
    logic        id_reg;
    logic        last_grant;
    logic [2:0]  cnt;
    logic        grant0;
    logic        grant1;

    // On a tie the requester that did not win last time gets the slot.
    always_comb begin
        grant0 = req0_valid && (!req1_valid || last_grant);
        grant1 = req1_valid && (!req0_valid || !last_grant);
    end

    assign req0_ready = (state == IDLE) && !reset && grant0;
    assign req1_ready = (state == IDLE) && !reset && grant1;

    assign alu_A   = op_reg[13:10];
    assign alu_B   = op_reg[9:6];
    assign alu_H   = op_reg[5:4];
    assign alu_S   = op_reg[3:1];
    assign alu_Cin = op_reg[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            op_reg     <= '0;
            id_reg     <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_F      <= '0;
            rsp_Cout   <= 1'b0;
            rsp_O      <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        op_reg     <= grant1 ? req1_op : req0_op;
                        id_reg     <= grant1;
                        last_grant <= grant1;
                        cnt        <= 3'(ALU_LAT);
                        state      <= EXEC;
                        busy       <= 1'b1;
                    end
                end
                EXEC: begin
                    if (cnt == 3'd0) begin
                        rsp_F     <= alu_F;
                        rsp_Cout  <= alu_Cout;
                        rsp_O     <= alu_O;
                        rsp_id    <= id_reg;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios then random traffic, all checked
// every cycle against a transaction-level model of the arbiter.
module tb_alu_arbiter;

    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [13:0] req0_op, req1_op;
    logic        req0_ready, req1_ready;
    logic [3:0]  alu_A, alu_B, alu_F, alu_O;
    logic [2:0]  alu_S;
    logic [1:0]  alu_H;
    logic        alu_Cin, alu_Cout;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_Cout, busy;
    logic [3:0]  rsp_F, rsp_O;

    int errors = 0;
    int checks = 0;

    // Model state: the operation in flight is described by when it was accepted.
    int          cyc = 0;
    int          acceptEdge = 0;
    bit          inFlight = 1'b0;
    bit          lastWasOne = 1'b1;
    logic [13:0] mOp = '0;
    bit          mId = 1'b0;
    logic [8:0]  mRsp = '0;
    bit          mRspId = 1'b0;
    bit          eReady0, eReady1, eRspValid;

    bit          grantLog[$];
    int          grantCyc[$];

    always #5 clk = ~clk;

    alu_arbiter #(.ALU_LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_ready(req1_ready),
        .alu_A(alu_A), .alu_B(alu_B), .alu_S(alu_S), .alu_H(alu_H), .alu_Cin(alu_Cin),
        .alu_F(alu_F), .alu_Cout(alu_Cout), .alu_O(alu_O),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_F(rsp_F), .rsp_Cout(rsp_Cout), .rsp_O(rsp_O), .busy(busy)
    );

    // Stub ALU+shifter: add/subtract by S[0], shifter acting on the ALU result.
    function automatic logic [8:0] aluModel(input logic [13:0] op);
        logic [3:0] a, b, f, o;
        logic [4:0] sum;
        a   = op[13:10];
        b   = op[9:6];
        sum = {1'b0, a} + {1'b0, (op[1] ? ~b : b)} + {4'b0, op[0]};
        f   = sum[3:0];
        case (op[5:4])
            2'd0:    o = f;
            2'd1:    o = {f[2:0], 1'b0};
            2'd2:    o = {1'b0, f[3:1]};
            default: o = {f[0], f[3:1]};
        endcase
        return {o, sum[4], f};
    endfunction

    always_comb {alu_O, alu_Cout, alu_F} = aluModel({alu_A, alu_B, alu_H, alu_S, alu_Cin});

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit v0, input logic [13:0] op0,
                                 input bit v1, input logic [13:0] op1, input bit rr);
        reset      = r;
        req0_valid = v0;
        req0_op    = op0;
        req1_valid = v1;
        req1_op    = op1;
        rsp_ready  = rr;
    endtask

    // One clock cycle: drive, check every output against the model, then advance the model.
    task automatic runCycle(input bit r, input bit v0, input logic [13:0] op0,
                            input bit v1, input logic [13:0] op1, input bit rr);
        @(negedge clk);
        applyStimulus(r, v0, op0, v1, op1, rr);
        #1;
        eReady0   = !r && !inFlight && v0 && (!v1 || lastWasOne);
        eReady1   = !r && !inFlight && v1 && (!v0 || !lastWasOne);
        eRspValid = inFlight && (cyc >= acceptEdge + LAT + 1);
        checkOutput("req0_ready", 32'(req0_ready), 32'(eReady0));
        checkOutput("req1_ready", 32'(req1_ready), 32'(eReady1));
        checkOutput("alu_A",      32'(alu_A),      32'(mOp[13:10]));
        checkOutput("alu_B",      32'(alu_B),      32'(mOp[9:6]));
        checkOutput("alu_H",      32'(alu_H),      32'(mOp[5:4]));
        checkOutput("alu_S",      32'(alu_S),      32'(mOp[3:1]));
        checkOutput("alu_Cin",    32'(alu_Cin),    32'(mOp[0]));
        checkOutput("busy",       32'(busy),       32'(inFlight));
        checkOutput("rsp_valid",  32'(rsp_valid),  32'(eRspValid));
        checkOutput("rsp_id",     32'(rsp_id),     32'(mRspId));
        checkOutput("rsp_F",      32'(rsp_F),      32'(mRsp[3:0]));
        checkOutput("rsp_Cout",   32'(rsp_Cout),   32'(mRsp[4]));
        checkOutput("rsp_O",      32'(rsp_O),      32'(mRsp[8:5]));
        if (req0_ready || req1_ready) begin
            grantLog.push_back(req1_ready);
            grantCyc.push_back(cyc);
        end
        @(posedge clk);
        cyc++;
        if (r) begin
            inFlight   = 1'b0;
            lastWasOne = 1'b1;
            mOp        = '0;
            mRsp       = '0;
            mRspId     = 1'b0;
        end else if (inFlight) begin
            if (eRspValid && rr) begin
                inFlight = 1'b0;
            end else if (cyc == acceptEdge + LAT + 1) begin
                mRsp   = aluModel(mOp);
                mRspId = mId;
            end
        end else if (eReady0 || eReady1) begin
            mOp        = eReady1 ? op1 : op0;
            mId        = eReady1;
            lastWasOne = eReady1;
            acceptEdge = cyc;
            inFlight   = 1'b1;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && inFlight; i++) runCycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        #1;
        checkOutput("drain_busy", 32'(busy), 32'd0);
    endtask

    bit          seq0101[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [13:0] op033 = {4'd5, 4'd3, 2'b00, 3'b000, 1'b0};
    bit          rs, nv0, nv1, nrr, pv0, pv1;
    logic [13:0] po0, po1;

    initial begin
        $display("[TB] alu_arbiter bench, ALU_LAT=%0d", LAT);
        applyStimulus(1'b1, 1'b1, 14'h3fff, 1'b1, 14'h1234, 1'b0);
        @(posedge clk);

        // Reset held with both requesters asking
        runCycle(1'b1, 1'b1, 14'h3fff, 1'b1, 14'h1234, 1'b1);
        runCycle(1'b1, 1'b1, 14'h3fff, 1'b1, 14'h1234, 1'b1);

        // Single op from requester 0 with known stub results
        runCycle(1'b0, 1'b1, op033, 1'b0, '0, 1'b0);
        #1;
        checkOutput("acc_alu_A", 32'(alu_A), 32'd5);
        checkOutput("acc_alu_B", 32'(alu_B), 32'd3);
        for (int i = 0; i < LAT + 1; i++) runCycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        #1;
        checkOutput("first_rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("first_rsp_id",    32'(rsp_id),    32'd0);
        checkOutput("first_rsp_F",     32'(rsp_F),     32'd8);
        checkOutput("first_rsp_O",     32'(rsp_O),     32'd8);
        drain();

        // Continuous tie from reset: alternating grants at fixed spacing
        runCycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        runCycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        grantLog.delete();
        grantCyc.delete();
        for (int i = 0; i < 4 * (LAT + 3); i++)
            runCycle(1'b0, 1'b1, 14'(16'h1a5 + i), 1'b1, 14'(16'h2c3 + i), 1'b1);
        checkOutput("rr_count", 32'(grantLog.size()), 32'd4);
        for (int i = 0; i < grantLog.size() && i < 4; i++) begin
            checkOutput("rr_order", 32'(grantLog[i]), 32'(seq0101[i]));
            if (i > 0) checkOutput("rr_spacing", 32'(grantCyc[i] - grantCyc[i-1]), 32'(LAT + 3));
        end
        drain();

        // Consumer stalls for 5 cycles while both requesters wait
        runCycle(1'b0, 1'b1, 14'h2b7d, 1'b0, '0, 1'b0);
        for (int i = 0; i < LAT + 1; i++) runCycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++) runCycle(1'b0, 1'b1, 14'h0f0f, 1'b1, 14'h3a3a, 1'b0);
        runCycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        #1;
        checkOutput("release_busy", 32'(busy), 32'd0);

        // Reset during EXEC, then a tie goes to requester 0
        runCycle(1'b0, 1'b1, 14'h1357, 1'b0, '0, 1'b0);
        runCycle(1'b1, 1'b1, 14'h1357, 1'b1, 14'h2468, 1'b0);
        grantLog.delete();
        runCycle(1'b0, 1'b1, 14'h0abc, 1'b1, 14'h3def, 1'b1);
        checkOutput("post_reset_grants", 32'(grantLog.size()), 32'd1);
        if (grantLog.size() > 0) checkOutput("post_reset_winner", 32'(grantLog[0]), 32'd0);
        drain();

        // Requester 1 alone for three operations
        grantLog.delete();
        for (int i = 0; i < 3 * (LAT + 3); i++)
            runCycle(1'b0, 1'b0, '0, 1'b1, 14'(16'h0777 + 16'(i * 97)), 1'b1);
        checkOutput("req1_only_count", 32'(grantLog.size()), 32'd3);
        foreach (grantLog[i]) checkOutput("req1_only_id", 32'(grantLog[i]), 32'd1);
        drain();

        // Random traffic with occasional resets and consumer back-pressure
        pv0 = 1'b0; pv1 = 1'b0; po0 = '0; po1 = '0;
        for (int i = 0; i < 300; i++) begin
            rs  = ($urandom_range(0, 39) == 0);
            nv0 = 1'($urandom_range(0, 1));
            nv1 = 1'($urandom_range(0, 1));
            nrr = ($urandom_range(0, 2) != 0);
            if (!(pv0 && !eReady0)) po0 = 14'($urandom);
            if (!(pv1 && !eReady1)) po1 = 14'($urandom);
            runCycle(rs, nv0, po0, nv1, po1, nrr);
            pv0 = nv0;
            pv1 = nv1;
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
